// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the fetch stage.
package fetch_pkg;
  localparam int unsigned PC_STEP = 4;

  // Queue pointers carry one extra wrap bit so that full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_if.sv
// Fetch stage handshakes: imem request/response channel and decode-side instruction port.
interface fetch_if #(
  parameter int W = 32
);
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_req_addr;
  logic         imem_rsp_valid;
  logic [W-1:0] imem_rsp_data;
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch queue: slots are allocated when a request is accepted and filled by responses.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int   W     = 32,
  parameter int   DEPTH = 4,
  localparam int  PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alloc_en,
  input  logic [W-1:0]  alloc_pc,
  input  logic          fill_en,
  input  logic [W-1:0]  fill_data,
  input  logic          pop_en,
  output logic [PW-1:0] occupancy,
  output logic [PW-1:0] unfilled,
  output logic          head_filled,
  output logic [W-1:0]  head_pc,
  output logic [W-1:0]  head_data
);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] data;
    logic         filled;
  } fetch_entry_t;

  fetch_entry_t  slots [DEPTH];
  logic [PW-1:0] alloc_q, fill_q, read_q;
  logic [IW-1:0] alloc_idx, fill_idx, read_idx;
  logic          do_fill, do_pop;

  assign alloc_idx   = alloc_q[IW-1:0];
  assign fill_idx    = fill_q[IW-1:0];
  assign read_idx    = read_q[IW-1:0];
  assign occupancy   = alloc_q - read_q;
  assign unfilled    = alloc_q - fill_q;
  assign head_filled = (occupancy != '0) && slots[read_idx].filled;
  assign head_pc     = slots[read_idx].pc;
  assign head_data   = slots[read_idx].data;
  assign do_fill     = fill_en && (unfilled != '0);
  assign do_pop      = pop_en && head_filled;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_q <= '0;
      fill_q  <= '0;
      read_q  <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (flush) begin
      alloc_q <= '0;
      fill_q  <= '0;
      read_q  <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
    end else begin
      if (alloc_en) begin
        slots[alloc_idx].pc     <= alloc_pc;
        slots[alloc_idx].filled <= 1'b0;
        alloc_q                 <= alloc_q + PW'(1);
      end
      // Responses return in request order, so the oldest unfilled slot is always the target.
      if (do_fill) begin
        slots[fill_idx].data   <= fill_data;
        slots[fill_idx].filled <= 1'b1;
        fill_q                 <= fill_q + PW'(1);
      end
      if (do_pop) read_q <= read_q + PW'(1);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, redirect/flush handling, stale-response dropping and request credit.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int           W        = 32,
  parameter int           DEPTH    = 4,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic         redirect_jalr,
  input  logic [W-1:0] redirect_base,
  input  logic [W-1:0] redirect_imm,
  fetch_if.master      bus,
  output logic         fetch_fault
);
  localparam int PW = ptr_w(DEPTH);

  logic [W-1:0]  pc_q, target_sum, target, head_pc, head_data;
  logic [PW-1:0] drop_cnt_q, occupancy, unfilled;
  logic [PW:0]   credit_used;
  logic          run_q, fault_q, head_filled, req_fire, rsp_drop, rsp_fill, pop;

  assign target_sum = redirect_base + redirect_imm;
  assign target     = redirect_jalr ? {target_sum[W-1:1], 1'b0} : target_sum;

  // Credit counts live slots plus responses still owed to a flushed stream.
  assign credit_used        = {1'b0, occupancy} + {1'b0, drop_cnt_q};
  assign bus.imem_req_valid = run_q && !fault_q && !redirect_valid &&
                              (credit_used < (PW+1)'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop           = bus.imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_fill           = bus.imem_rsp_valid && (drop_cnt_q == '0);

  assign bus.instr_valid = head_filled && !redirect_valid;
  assign bus.instr       = bus.instr_valid ? head_data : '0;
  assign bus.instr_pc    = bus.instr_valid ? head_pc : '0;
  assign pop             = bus.instr_valid && bus.instr_ready;
  assign fetch_fault     = fault_q;

  fetch_queue #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid),
    .alloc_en    (req_fire),
    .alloc_pc    (pc_q),
    .fill_en     (rsp_fill),
    .fill_data   (bus.imem_rsp_data),
    .pop_en      (pop),
    .occupancy   (occupancy),
    .unfilled    (unfilled),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_data   (head_data)
  );

  // run_q keeps the request port quiet while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      fault_q    <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        pc_q       <= target;
        drop_cnt_q <= drop_cnt_q + unfilled - PW'(bus.imem_rsp_valid);
        fault_q    <= (target[1:0] != 2'b00);
      end else begin
        if (req_fire) pc_q <= pc_q + W'(PC_STEP);
        if (rsp_drop) drop_cnt_q <= drop_cnt_q - PW'(1);
      end
    end
  end

  // A response with nothing outstanding means the memory invented a beat.
  assert property (@(posedge clk) disable iff (!rst)
    bus.imem_rsp_valid |-> ((drop_cnt_q != '0) || (unfilled != '0)));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency instruction memory model.
module tb_fetch_unit;
  logic        clk, rst;
  logic        redirect_valid, redirect_jalr, fetch_fault;
  logic [31:0] redirect_base, redirect_imm;

  fetch_if #(.W(32)) bus ();

  fetch_unit #(.W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_jalr  (redirect_jalr),
    .redirect_base  (redirect_base),
    .redirect_imm   (redirect_imm),
    .bus            (bus),
    .fetch_fault    (fetch_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] acc_log[$], pop_pc_log[$], pop_ins_log[$];
  int          acc_cyc[$], pop_cyc[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          n_tests = 0;
  int          n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Edge monitor: sees pre-edge values, records accepts/pops and retires responses.
  always @(posedge clk) begin
    if (rst) begin
      if (bus.imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
        acc_log.push_back(bus.imem_req_addr);
        acc_cyc.push_back(cyc);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        pop_pc_log.push_back(bus.instr_pc);
        pop_ins_log.push_back(bus.instr);
        pop_cyc.push_back(cyc);
      end
    end
    cyc++;
  end

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_pc_log.size()) ? pop_pc_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] ins_at(input int i);
    return (i < pop_ins_log.size()) ? pop_ins_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic int acc_cyc_at(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1000;
  endfunction

  function automatic int pop_cyc_at(input int i);
    return (i < pop_cyc.size()) ? pop_cyc[i] : -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    acc_cyc.delete();
    pop_pc_log.delete();
    pop_ins_log.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset(input logic rdy, input logic irdy, input int lat);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_jalr  = 1'b0;
    redirect_base  = '0;
    redirect_imm   = '0;
    bus.imem_req_ready = rdy;
    bus.instr_ready    = irdy;
    mem_lat        = lat;
    tick(2);
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic redirect(input logic jalr, input logic [31:0] base, input logic [31:0] imm);
    redirect_valid = 1'b1;
    redirect_jalr  = jalr;
    redirect_base  = base;
    redirect_imm   = imm;
    tick(1);
    redirect_valid = 1'b0;
    redirect_jalr  = 1'b0;
    redirect_base  = '0;
    redirect_imm   = '0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_jalr  = 1'b0;
    redirect_base  = '0;
    redirect_imm   = '0;
    bus.imem_req_ready = 1'b0;
    bus.instr_ready    = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_req_addr", bus.imem_req_addr, 32'h0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);

    // 1: sequential stream, L=1, full throughput
    do_reset(1'b1, 1'b1, 1);
    tick(12);
    for (int i = 0; i < 6; i++) check($sformatf("t1_acc%0d", i), acc_at(i), 32'(4 * i));
    for (int i = 0; i < 5; i++) check($sformatf("t1_pop%0d", i), pop_at(i), 32'(4 * i));
    check("t1_ins0", ins_at(0), mem_word(32'h0));
    check("t1_ins3", ins_at(3), mem_word(32'hC));
    check("t1_latency", 32'(pop_cyc_at(0) - acc_cyc_at(0)), 32'd2);
    check("t1_pop_rate", 32'(pop_cyc_at(4) - pop_cyc_at(0)), 32'd4);
    check("t1_acc_rate", 32'(acc_cyc_at(5) - acc_cyc_at(0)), 32'd5);

    // 2: decode stalled -> queue fills to DEPTH, then drains in order
    do_reset(1'b1, 1'b0, 1);
    tick(10);
    check("t2_acc_count", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_acc%0d", i), acc_at(i), 32'(4 * i));
    check("t2_req_blocked", 32'(bus.imem_req_valid), 32'd0);
    check("t2_head_valid", 32'(bus.instr_valid), 32'd1);
    check("t2_head_pc", bus.instr_pc, 32'h0);
    check("t2_head_instr", bus.instr, mem_word(32'h0));
    bus.instr_ready = 1'b1;
    tick(8);
    for (int i = 0; i < 4; i++) check($sformatf("t2_pop%0d", i), pop_at(i), 32'(4 * i));
    check("t2_resume", acc_at(4), 32'h10);

    // 3: L=3, redirect with two responses outstanding
    do_reset(1'b0, 1'b1, 3);
    tick(3);
    check("t3_req_waiting", 32'(bus.imem_req_valid), 32'd1);
    bus.imem_req_ready = 1'b1;
    tick(2);
    bus.imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_jalr  = 1'b0;
    redirect_base  = 32'h8;
    redirect_imm   = 32'h100;
    #1;
    check("t3_redir_gates_req", 32'(bus.imem_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    #1;
    check("t3_next_addr", bus.imem_req_addr, 32'h108);
    check("t3_acc_before", 32'(acc_log.size()), 32'd2);
    tick(15);
    check("t3_acc2", acc_at(2), 32'h108);
    check("t3_acc3", acc_at(3), 32'h10C);
    check("t3_pop0", pop_at(0), 32'h108);
    check("t3_pop1", pop_at(1), 32'h10C);
    check("t3_ins0", ins_at(0), mem_word(32'h108));

    // 4: misaligned JALR target faults; aligned JALR (bit0 masked) clears it
    do_reset(1'b1, 1'b1, 1);
    tick(5);
    redirect(1'b1, 32'h203, 32'h0);
    clear_logs();
    check("t4_fault_set", 32'(fetch_fault), 32'd1);
    check("t4_req_off", 32'(bus.imem_req_valid), 32'd0);
    check("t4_pc_target", bus.imem_req_addr, 32'h202);
    check("t4_queue_empty", 32'(bus.instr_valid), 32'd0);
    tick(5);
    check("t4_no_acc", 32'(acc_log.size()), 32'd0);
    check("t4_no_pop", 32'(pop_pc_log.size()), 32'd0);
    check("t4_fault_sticky", 32'(fetch_fault), 32'd1);
    redirect(1'b1, 32'h41, 32'h0);
    check("t4_fault_clear", 32'(fetch_fault), 32'd0);
    check("t4_new_pc", bus.imem_req_addr, 32'h40);
    tick(6);
    check("t4_acc0", acc_at(0), 32'h40);
    check("t4_pop0", pop_at(0), 32'h40);

    // 5: redirect coinciding with a pop and a response; negative branch offset
    do_reset(1'b1, 1'b1, 1);
    tick(6);
    redirect_valid = 1'b1;
    redirect_jalr  = 1'b0;
    redirect_base  = 32'h100;
    redirect_imm   = 32'hFFFF_FFF0;
    #1;
    check("t5_pop_void", 32'(bus.instr_valid), 32'd0);
    check("t5_pc_masked", bus.instr_pc, 32'h0);
    clear_logs();
    tick(1);
    redirect_valid = 1'b0;
    redirect_base  = '0;
    redirect_imm   = '0;
    #1;
    check("t5_empty", 32'(bus.instr_valid), 32'd0);
    check("t5_instr_zero", bus.instr, 32'h0);
    check("t5_no_pop", 32'(pop_pc_log.size()), 32'd0);
    check("t5_target", bus.imem_req_addr, 32'hF0);
    tick(6);
    check("t5_acc0", acc_at(0), 32'hF0);
    check("t5_pop0", pop_at(0), 32'hF0);
    check("t5_pop1", pop_at(1), 32'hF4);

    // 6: PC wraps past 2^32, then async reset mid-burst
    redirect(1'b0, 32'hFFFF_FFF0, 32'h8);
    clear_logs();
    tick(4);
    check("t6_acc0", acc_at(0), 32'hFFFF_FFF8);
    check("t6_acc1", acc_at(1), 32'hFFFF_FFFC);
    check("t6_acc2", acc_at(2), 32'h0000_0000);
    check("t6_acc3", acc_at(3), 32'h0000_0004);
    check("t6_pop0", pop_at(0), 32'hFFFF_FFF8);
    check("t6_pop1", pop_at(1), 32'hFFFF_FFFC);
    check("t6_busy", 32'(bus.instr_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("t6_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("t6_rst_instr", bus.instr, 32'h0);
    check("t6_rst_instr_pc", bus.instr_pc, 32'h0);
    check("t6_rst_addr", bus.imem_req_addr, 32'h0);
    check("t6_rst_fault", 32'(fetch_fault), 32'd0);
    tick(2);
    rst = 1'b1;
    clear_logs();
    tick(6);
    check("t6_restart0", acc_at(0), 32'h0);
    check("t6_restart1", acc_at(1), 32'h4);
    check("t6_restart_pop", pop_at(0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
